reg_dump_ctrl: RTL

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/reg_dump_pkg.sv | 16 +
 rtl/cycle_trigger.sv | 41 ++++
 rtl/reg_dump_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and helpers for the register dump controller.
package reg_dump_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_e;

    localparam int CNT_W = 32;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cycle_trigger.sv
// Enabled-cycle counter with a (optionally periodic) trigger point.
module cycle_trigger
    import reg_dump_pkg::*;
#(
    parameter int END_COUNT = 25,
    parameter int PERIOD    = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cnt_en_i,
    output logic             trig_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] next_trig_q;
    logic [CNT_W-1:0] next_trig_d;
    logic             advance;

    // The trigger fires on the edge where the count lands on next_trig.
    always_comb begin
        advance     = cnt_en_i && (count_q != '1);
        count_d     = advance ? count_q + CNT_W'(1) : count_q;
        trig_o      = advance && (count_d == next_trig_q);
        next_trig_d = trig_o ? next_trig_q + CNT_W'(PERIOD) : next_trig_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q     <= '0;
            next_trig_q <= CNT_W'(END_COUNT);
        end else begin
            count_q     <= count_d;
            next_trig_q <= next_trig_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/reg_dump_ctrl.sv
// Snapshots a register file at trigger points and streams it out
// one entry per accepted beat over a valid/ready port.
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 13,
    parameter int END_COUNT = 25,
    parameter int PERIOD    = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [NUM_REGS*DATA_W-1:0]   rf_flat_i,
    input  logic                         dump_ready_i,
    output logic                         dump_valid_o,
    output logic [idx_w(NUM_REGS)-1:0]   dump_idx_o,
    output logic [DATA_W-1:0]            dump_data_o,
    output logic                         dump_last_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         overrun_o,
    output logic [31:0]                  cycle_o
);

    localparam int IDX_W = idx_w(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    dump_state_e                 state_q;
    dump_state_e                 state_d;
    logic [IDX_W-1:0]            idx_q;
    logic [IDX_W-1:0]            idx_d;
    logic                        overrun_q;
    logic                        overrun_d;
    logic                        valid_q;
    logic                        valid_d;
    logic                        done_q;
    logic                        done_d;
    logic [NUM_REGS*DATA_W-1:0]  shadow_q;
    logic [NUM_REGS*DATA_W-1:0]  shadow_d;
    logic                        capture;
    logic                        beat;
    logic                        trig;
    logic                        cnt_en;
    logic [CNT_W-1:0]            count;

    assign cnt_en = en_i && (state_q != DONE);

    cycle_trigger #(
        .END_COUNT (END_COUNT),
        .PERIOD    (PERIOD)
    ) u_trig (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cnt_en_i  (cnt_en),
        .trig_o    (trig),
        .count_o   (count)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        beat      = valid_q && dump_ready_i;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    capture = 1'b1;
                end
            end
            STREAM: begin
                // A trigger arriving mid-stream is dropped but remembered.
                if (trig) begin
                    overrun_d = 1'b1;
                end
                if (beat) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (PERIOD > 0) ? IDLE : DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d  = (state_d == STREAM);
        done_d   = (state_d == DONE);
        shadow_d = capture ? rf_flat_i : shadow_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // The snapshot survives reset; only the stream state is cleared.
    always_ff @(posedge clk_i) begin
        shadow_q <= shadow_d;
    end

    always_comb begin
        dump_data_o = '0;
        if (valid_q) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    dump_data_o = shadow_q[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign dump_valid_o = valid_q;
    assign dump_idx_o   = valid_q ? idx_q : '0;
    assign dump_last_o  = valid_q && (idx_q == LAST_IDX);
    assign busy_o       = valid_q;
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;
    assign cycle_o      = count;

endmodule
